stereolbm_deadlock_report_unit: RTL and testbench

Aggregates the per-process `block` outputs of the HLS deadlock monitors in the stereolbm_axis_cambm dataflow region and decides whether a true deadlock exists. It consumes the monitor outputs directly, requires a stable blocked pattern to persist for a programmable window, then latches a deadlock flag, the offending pattern and the lowest offending monitor index. It sits between the monitor array and the simulation/debug reporting logic.

---
 rtl/stereolbm_deadlock_report_unit.sv | 73 +++++++
 tb/tb_stereolbm_deadlock_report_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/stereolbm_deadlock_report_unit.sv
// stereolbm_deadlock_report_unit: latches a deadlock when a non-zero monitor block pattern stays constant for PERSIST cycles; ports clock/reset, mon_block/all_idle/clear in, deadlock/deadlock_pulse/snapshot/first_idx/event_cnt out; STEREOLBM_DLK_AUTOCLR_EN lets idle/unblocked release DEADLOCK
module stereolbm_deadlock_report_unit #(
  parameter int NUM_MON = 12,
  parameter int PERSIST = 1024,
  parameter int CNT_W = 16,
  parameter int IDX_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               all_idle,
  input  logic               clear,
  output logic               deadlock,
  output logic               deadlock_pulse,
  output logic [NUM_MON-1:0] snapshot,
  output logic [IDX_W-1:0]   first_idx,
  output logic [7:0]         event_cnt
);
  typedef enum logic [1:0] {IDLE, ARMING, DEADLOCK} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] low_idx;
  logic leave;
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) low_idx = snapshot[i] ? IDX_W'(i) : low_idx;
  end
`ifdef STEREOLBM_DLK_AUTOCLR_EN
  assign leave = clear || all_idle || mon_block == '0;
`else
  assign leave = clear;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      deadlock <= 1'b0;
      deadlock_pulse <= 1'b0;
      snapshot <= '0;
      first_idx <= '0;
      event_cnt <= '0;
    end else begin
      deadlock_pulse <= 1'b0;
      case (state)
        IDLE: if (mon_block != '0 && !all_idle) begin
          state <= ARMING;
          snapshot <= mon_block;
          cnt <= '0;
        end
        ARMING: if (all_idle || mon_block == '0) begin
          state <= IDLE;
          cnt <= '0;
        end else if (mon_block != snapshot) begin
          snapshot <= mon_block;
          cnt <= '0;
        end else if (cnt == CNT_W'(PERSIST - 1)) begin
          state <= DEADLOCK;
          deadlock <= 1'b1;
          deadlock_pulse <= 1'b1;
          event_cnt <= event_cnt + {7'd0, event_cnt != 8'hff};
          first_idx <= low_idx;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DEADLOCK: if (leave) begin
          state <= IDLE;
          deadlock <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stereolbm_deadlock_report_unit.sv
// tb_stereolbm_deadlock_report_unit: scoreboard bench against a run-length reference model
module tb_stereolbm_deadlock_report_unit;
  localparam int NM = 12;
  localparam int P = 8;
  logic clock = 1'b0;
  logic reset, all_idle, clear;
  logic [NM-1:0] mon_block;
  logic deadlock, deadlock_pulse;
  logic [NM-1:0] snapshot;
  logic [5:0] first_idx;
  logic [7:0] event_cnt;
  int checks = 0, passed = 0, cyc = 0;
  logic [27:0] exp_q[$];
  bit done = 0;
  int run = 0, ev = 0;
  bit lat = 0, pulse = 0;
  logic [NM-1:0] snap = '0;
  logic [5:0] fidx = '0;

  stereolbm_deadlock_report_unit #(.NUM_MON(NM), .PERSIST(P), .CNT_W(16), .IDX_W(6)) dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .all_idle(all_idle), .clear(clear),
    .deadlock(deadlock), .deadlock_pulse(deadlock_pulse), .snapshot(snapshot),
    .first_idx(first_idx), .event_cnt(event_cnt));

  always #5 clock = ~clock;

`ifdef STEREOLBM_DLK_AUTOCLR_EN
  localparam bit AUTOCLR = 1'b1;
`else
  localparam bit AUTOCLR = 1'b0;
`endif

  // Deadlock = PERSIST+1 consecutive samples of the same non-zero pattern with the region busy.
  task automatic step(input logic [NM-1:0] mb, input bit ai, input bit cl, input bit rst);
    reset = rst; mon_block = mb; all_idle = ai; clear = cl;
    pulse = 0;
    if (rst) begin
      run = 0; lat = 0; snap = '0; fidx = '0; ev = 0;
    end else if (lat) begin
      if (cl || (AUTOCLR && (mb == 0 || ai))) begin lat = 0; run = 0; end
    end else if (mb == 0 || ai) begin
      run = 0;
    end else begin
      run = (run > 0 && mb == snap) ? run + 1 : 1;
      snap = mb;
      if (run == P + 1) begin
        lat = 1; pulse = 1; run = 0;
        ev = ev < 255 ? ev + 1 : 255;
        for (int k = 0; k < NM; k++) if (snap[k]) begin fidx = 6'(k); break; end
      end
    end
    exp_q.push_back({lat, pulse, snap, fidx, 8'(ev)});
    @(negedge clock);
  endtask

  task automatic hold(input logic [NM-1:0] mb, input int n);
    for (int k = 0; k < n; k++) step(mb, 0, 0, 0);
  endtask

  initial begin : monitor
    logic [27:0] e, a;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {deadlock, deadlock_pulse, snapshot, first_idx, event_cnt};
        checks++;
        if (a == e) passed++;
        else $display("FAIL outputs cyc %0d: got dl=%b pl=%b snap=%h idx=%0d ev=%0d, want dl=%b pl=%b snap=%h idx=%0d ev=%0d",
          cyc, a[27], a[26], a[25:14], a[13:8], a[7:0], e[27], e[26], e[25:14], e[13:8], e[7:0]);
        cyc++;
      end
    end
  end

  initial begin : stim
    logic [NM-1:0] mb;
    step('0, 0, 0, 1);
    step('0, 0, 0, 1);
    hold(12'h010, 12);
    step(12'h010, 0, 1, 0);
    step('0, 0, 0, 0);
    hold(12'h030, 5);
    hold(12'h020, 12);
    step('0, 0, 1, 0);
    hold(12'h001, 7);
    hold('0, 3);
    hold(12'h001, 6);
    for (int k = 0; k < 4; k++) step(12'h001, 1, 0, 0);
    hold(12'h040, 7);
    hold(12'h080, 1);
    hold(12'h080, 10);
    hold('0, 20);
    step('0, 0, 1, 0);
    hold('0, 2);
    hold(12'h800, 10);
    for (int k = 0; k < 5; k++) step(12'h800, 1, 0, 0);
    step(12'h800, 0, 1, 0);
    for (int k = 0; k < 300; k++) begin
      hold(12'hA00, 9);
      step(12'hA00, 0, 1, 0);
    end
    hold(12'h004, 10);
    step(12'h004, 0, 0, 1);
    step(12'h004, 0, 0, 0);
    hold(12'h004, 5);
    step(12'h004, 0, 0, 1);
    mb = 12'h010;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0)
        case ($urandom_range(0, 3))
          0: mb = '0;
          1: mb = 12'h010;
          2: mb = 12'h800;
          default: mb = 12'($urandom);
        endcase
      step(mb, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
    end
    done = 1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL timeout: run did not complete, got %0d checks, want finish", checks);
      $fatal(1);
    end
  end
endmodule
